// File: rtl/clkgen_rst_seq_pkg.sv
// Shared types and sizing helpers for the clock-generator reset sequencer.
package clkgen_rst_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STRETCH,
    RELEASE,
    RUN
  } rst_seq_state_e;

  function automatic int seq_cnt_width(input int stretch_cycles, input int gap_cycles);
    int m;
    m = (stretch_cycles > gap_cycles) ? stretch_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer with a configurable reset value.
module prim_flop_2sync #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= ResetValue;
      r_sync <= ResetValue;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clkgen_rst_seq.sv
// Lock/reset sequencer: stretches a synchronized "ok" and releases domain resets in order.
// States: IDLE all held | STRETCH counting ok | RELEASE stepping stages | RUN all released.
module clkgen_rst_seq
  import clkgen_rst_seq_pkg::*;
#(
  parameter int NumStages     = 3,
  parameter int StretchCycles = 16,
  parameter int GapCycles     = 4,
  parameter int CntW          = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 locked_i,
  input  logic                 rst_req_ni,
  input  logic                 srst_req_ni,
  output logic [NumStages-1:0] rst_no,
  output logic                 rst_done_o,
  output logic [CntW-1:0]      lock_loss_cnt_o
);

  localparam int                   CW          = seq_cnt_width(StretchCycles, GapCycles);
  localparam logic [CW-1:0]        StretchMax  = CW'(StretchCycles);
  localparam logic [CW-1:0]        GapMax      = CW'(GapCycles);
  localparam logic [NumStages-1:0] FirstStage  = NumStages'(1);

  logic w_locked_s, w_rst_req_ns, w_srst_req_ns, w_ok;

  prim_flop_2sync #(.Width(1), .ResetValue(1'b0)) u_sync_locked (
    .i_clk(clk_i), .i_rst(rst_i), .i_d(locked_i), .o_q(w_locked_s)
  );
  prim_flop_2sync #(.Width(1), .ResetValue(1'b0)) u_sync_rst_req (
    .i_clk(clk_i), .i_rst(rst_i), .i_d(rst_req_ni), .o_q(w_rst_req_ns)
  );
  prim_flop_2sync #(.Width(1), .ResetValue(1'b0)) u_sync_srst_req (
    .i_clk(clk_i), .i_rst(rst_i), .i_d(srst_req_ni), .o_q(w_srst_req_ns)
  );

  assign w_ok = w_locked_s & w_rst_req_ns & w_srst_req_ns;

  rst_seq_state_e        r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [NumStages-1:0]  r_rst_n, w_rst_n_nxt, w_rst_n_shift;
  logic                  r_done, w_done_nxt;
  logic [CntW-1:0]       r_llc, w_llc_nxt;

  assign w_cnt_inc     = r_cnt + CW'(1);
  assign w_rst_n_shift = NumStages'({r_rst_n, 1'b1});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rst_n <= '0;
      r_done  <= 1'b0;
      r_llc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_done  <= w_done_nxt;
      r_llc   <= w_llc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_n_nxt = r_rst_n;
    w_done_nxt  = r_done;
    w_llc_nxt   = r_llc;
    // Losing ok drops every stage at once from any state; no ordered assertion.
    if (!w_ok) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_rst_n_nxt = '0;
      w_done_nxt  = 1'b0;
      if (r_state == RUN && !w_locked_s && r_llc != {CntW{1'b1}}) begin
        w_llc_nxt = r_llc + CntW'(1);
      end
    end else begin
      case (r_state)
        IDLE, STRETCH: begin
          if (w_cnt_inc >= StretchMax) begin
            w_cnt_nxt   = '0;
            w_rst_n_nxt = FirstStage;
            w_done_nxt  = &FirstStage;
            w_state_nxt = (&FirstStage) ? RUN : RELEASE;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = STRETCH;
          end
        end
        RELEASE: begin
          if (w_cnt_inc >= GapMax) begin
            w_cnt_nxt   = '0;
            w_rst_n_nxt = w_rst_n_shift;
            if (&w_rst_n_shift) begin
              w_state_nxt = RUN;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_no          = r_rst_n;
  assign rst_done_o      = r_done;
  assign lock_loss_cnt_o = r_llc;

endmodule

// File: doc/clkgen_rst_seq.md
Name: clkgen_rst_seq

Overview:
- Consumer side of the FPGA clock generator's lock/reset output.
- Takes the raw PLL lock and external reset requests, synchronizes them into the main clock domain and stretches them.
- Releases NumStages domain resets in a fixed order with programmable gaps, then reports completion.
- Sits in the FPGA top between the clock generator and the reset manager/core reset inputs.

Parameters:
- NumStages, 3, number of sequenced active-low reset outputs, 1..8.
- StretchCycles, 16, consecutive cycles all release conditions must hold before stage 0 releases, >=1.
- GapCycles, 4, cycles between releases of consecutive stages, >=1.
- CntW, 8, width of the lock-loss event counter.

Ports:
- clk_i  in  1  main clock; all logic is in this domain.
- rst_i  in  1  asynchronous active-high reset.
- locked_i  in  1  PLL lock, asynchronous to clk_i.
- rst_req_ni  in  1  external pushbutton reset, active low, asynchronous.
- srst_req_ni  in  1  debug/system reset request, active low, asynchronous.
- rst_no  out  NumStages  sequenced domain resets, active low; bit 0 releases first.
- rst_done_o  out  1  high while every stage is released (RUN state).
- lock_loss_cnt_o  out  CntW  saturating count of lock-loss events seen in RUN.

Behaviour:
- Reset: rst_i asserts asynchronously. While it is high, every output is held at its reset value:
  - rst_no = all 0 (all domains held in reset)
  - rst_done_o = 0
  - lock_loss_cnt_o = 0
  - FSM in IDLE
- Sync: locked_i, rst_req_ni and srst_req_ni each pass through a 2-flop synchronizer.
  - Synchronizer reset values: locked = 0; rst_req_n and srst_req_n = 0, i.e. requests treated as asserted.
  - ok = locked_s & rst_req_ns & srst_req_ns. ok is visible 2 cycles after an input change.
- FSM states: IDLE, STRETCH, RELEASE, RUN. All outputs are registered.
- IDLE:
  - rst_no = 0, stretch counter cleared.
  - ok -> STRETCH, with the counter loaded to 1.
- STRETCH:
  - Counts consecutive ok cycles.
  - !ok -> IDLE.
  - When the counter reaches StretchCycles and ok still holds -> RELEASE, stage index 0, gap counter 0, rst_no[0] set to 1 on the same edge.
- RELEASE:
  - The gap counter increments each cycle.
  - When it reaches GapCycles: set the next rst_no bit, increment the index, clear the counter.
  - When the last bit is set: transition to RUN and set rst_done_o to 1 on the same edge.
  - If NumStages == 1, STRETCH goes directly to RUN.
- RUN: outputs stable until !ok.
- Leaving STRETCH, RELEASE or RUN on !ok:
  - Next edge: state IDLE, rst_no = 0 for all bits simultaneously, rst_done_o = 0.
  - No ordered assertion.
- Lock-loss counter:
  - Increments by 1 on the edge leaving RUN when locked_s == 0, whatever the other requests are.
  - Saturates at 2^CntW-1; never wraps.
  - Cleared only by rst_i.
- ok glitches shorter than StretchCycles during STRETCH restart the stretch from IDLE; no partial release ever occurs.
- Latencies with ok inputs going high at edge 0 and defaults:
  - rst_no[0] rises at edge 2+StretchCycles = 18.
  - rst_no[k] rises at 18+k*GapCycles: 22, 26.
  - rst_done_o rises at 26.
- Assertion latency from any ok input falling to rst_no = 0 is 3 edges (2 sync + 1 register).
- rst_i asserted mid-sequence: immediate (asynchronous) return to reset values, counter included.

Decomposition:
- Package clkgen_rst_seq_pkg holds:
  - state enum rst_seq_state_e {IDLE, STRETCH, RELEASE, RUN}
  - a function returning the counter width $clog2(max(StretchCycles,GapCycles)+1)
- Synchronizers are instances of the codebase's existing prim_flop_2sync, reset to the values above. No other sub-module.

Test Plan:
- Defaults, all inputs go high at edge 0 -> rst_no 3'b001@18, 3'b011@22, 3'b111@26; rst_done_o=1@26; lock_loss_cnt_o=0.
- In RUN, locked_i low for 5 cycles -> rst_no=3'b000 and rst_done_o=0 3 edges later; lock_loss_cnt_o=1. After locked_i returns, the sequence repeats with the same timing.
- In STRETCH, rst_req_ni pulses low for 2 cycles at ok-count 10 -> no rst_no bit ever rises during the attempt; stage 0 releases StretchCycles cycles after ok is stable again.
- In RELEASE (rst_no=3'b011), srst_req_ni low -> all bits drop on one edge; lock_loss_cnt_o unchanged.
- CntW=2, four lock-loss events from RUN -> counter reads 1, 2, 3, 3.
- rst_i asserted in RUN -> rst_no=0, rst_done_o=0 and lock_loss_cnt_o=0 immediately, before the next clock edge; full sequence again after rst_i drops.
